aemb_dwb_ctrl: RTL and testbench

Data Wishbone bus controller for the aeMB core. It accepts load/store requests from the execute stage and generates big-endian byte selects. It runs a single-outstanding Wishbone classic cycle and stalls the pipeline through gena_o until the access completes or times out. It captures the raw load word and holds the byte-select stable for the register-file load sizer during write-back.

---
 rtl/aemb_dwb_ctrl.sv | 158 +++++++++++++++
 tb/tb_aemb_dwb_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aemb_dwb_ctrl.sv
// aeMB data Wishbone bus controller.
// Accepts load/store requests from execute, encodes big-endian byte selects,
// runs one Wishbone classic cycle at a time and stalls the pipeline through
// gena_o until the access is acknowledged or times out. The raw load word and
// the byte select are held for the register-file load sizer during write-back.
// The read-data input dwb_dat_i carries the load word captured on acknowledge.
module aemb_dwb_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNTW    = 16
) (
   input  logic        gclk,
   input  logic        grst,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] adr_i,
   output logic        gena_o,
   output logic        err_o,
   output logic [3:0]  sel_o,
   output logic [31:0] ld_dat_o,
   output logic        dwb_cyc_o,
   output logic        dwb_stb_o,
   output logic        dwb_we_o,
   output logic [29:0] dwb_adr_o,
   output logic [3:0]  dwb_sel_o,
   input  logic        dwb_ack_i,
   input  logic [31:0] dwb_dat_i
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   // Last counter value before an unacknowledged access is abandoned.
   localparam logic [CNTW-1:0] TO_LAST = CNTW'(TIMEOUT - 1);

   // Returns {aligned, select}; select is big-endian (byte 0 on lane 3).
   function automatic logic [4:0] enc_sel(input logic [1:0] size, input logic [1:0] a);
      logic [4:0] r;
      case ({size, a})
         4'b00_00: r = 5'b1_1000;
         4'b00_01: r = 5'b1_0100;
         4'b00_10: r = 5'b1_0010;
         4'b00_11: r = 5'b1_0001;
         4'b01_00: r = 5'b1_1100;
         4'b01_10: r = 5'b1_0011;
         4'b10_00: r = 5'b1_1111;
         default:  r = 5'b0_0000;
      endcase
      return r;
   endfunction

   state_t          state_q;
   logic [CNTW-1:0] cnt_q;
   logic            gena_q;
   logic            err_q;
   logic [3:0]      sel_q;
   logic [31:0]     ld_dat_q;
   logic            cyc_q;
   logic            stb_q;
   logic            we_q;
   logic [29:0]     adr_q;
   logic [3:0]      wsel_q;

   logic [4:0]      acc_sel_d;
   logic            acc_ok_d;

   assign acc_sel_d = enc_sel(size_i, adr_i[1:0]);
   assign acc_ok_d  = acc_sel_d[4];

   // Bus FSM: request acceptance, wait/timeout tracking and registered outputs.
   always_ff @(posedge gclk) begin
      if (grst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gena_q   <= 1'b1;
         err_q    <= 1'b0;
         sel_q    <= 4'h0;
         ld_dat_q <= 32'h0;
         cyc_q    <= 1'b0;
         stb_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= 30'h0;
         wsel_q   <= 4'h0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            // gena_o is high in both IDLE and WB, so requests are sampled here.
            ST_IDLE, ST_WB: begin
               if (req_i) begin
                  if (acc_ok_d) begin
                     state_q <= ST_BUS;
                     cyc_q   <= 1'b1;
                     stb_q   <= 1'b1;
                     we_q    <= we_i;
                     adr_q   <= adr_i[31:2];
                     wsel_q  <= acc_sel_d[3:0];
                     sel_q   <= acc_sel_d[3:0];
                     gena_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                     err_q   <= 1'b1;
                     gena_q  <= 1'b1;
                  end
               end else begin
                  state_q <= ST_IDLE;
                  gena_q  <= 1'b1;
               end
            end
            ST_BUS: begin
               if (dwb_ack_i) begin
                  state_q <= ST_WB;
                  cyc_q   <= 1'b0;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                  gena_q  <= 1'b1;
                  if (!we_q) begin
                     ld_dat_q <= dwb_dat_i;
                  end else begin
                     ld_dat_q <= ld_dat_q;
                  end
               end else if (cnt_q == TO_LAST) begin
                  state_q  <= ST_WB;
                  cyc_q    <= 1'b0;
                  stb_q    <= 1'b0;
                  we_q     <= 1'b0;
                  gena_q   <= 1'b1;
                  err_q    <= 1'b1;
                  ld_dat_q <= 32'h0;
               end else begin
                  cnt_q <= cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cyc_q   <= 1'b0;
               stb_q   <= 1'b0;
               we_q    <= 1'b0;
               gena_q  <= 1'b1;
            end
         endcase
      end
   end

   assign gena_o    = gena_q;
   assign err_o     = err_q;
   assign sel_o     = sel_q;
   assign ld_dat_o  = ld_dat_q;
   assign dwb_cyc_o = cyc_q;
   assign dwb_stb_o = stb_q;
   assign dwb_we_o  = we_q;
   assign dwb_adr_o = adr_q;
   assign dwb_sel_o = wsel_q;

endmodule

// File: tb/tb_aemb_dwb_ctrl.sv
// Self-checking bench for aemb_dwb_ctrl: directed vector table, hand-written
// back-to-back and reset sequences, and randomized transactions checked
// against a transaction-level reference model.
module tb_aemb_dwb_ctrl;

   localparam int TO = 4;

   logic        gclk;
   logic        grst;
   logic        req_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic [31:0] adr_i;
   logic        gena_o;
   logic        err_o;
   logic [3:0]  sel_o;
   logic [31:0] ld_dat_o;
   logic        dwb_cyc_o;
   logic        dwb_stb_o;
   logic        dwb_we_o;
   logic [29:0] dwb_adr_o;
   logic [3:0]  dwb_sel_o;
   logic        dwb_ack_i;
   logic [31:0] dwb_dat_i;

   int n_chk;
   int n_fail;
   logic [31:0] model_ld;

   aemb_dwb_ctrl #(.TIMEOUT(TO), .CNTW(16)) dut (
      .gclk(gclk), .grst(grst), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .adr_i(adr_i), .gena_o(gena_o), .err_o(err_o), .sel_o(sel_o),
      .ld_dat_o(ld_dat_o), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o),
      .dwb_we_o(dwb_we_o), .dwb_adr_o(dwb_adr_o), .dwb_sel_o(dwb_sel_o),
      .dwb_ack_i(dwb_ack_i), .dwb_dat_i(dwb_dat_i)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] adr;
      int          waits;
      logic [31:0] dat;
      logic [3:0]  exp_sel;
      logic        exp_mis;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference select: n = 2^size bytes, aligned when A is a multiple of n;
   // big-endian lanes place byte A at bit (3-A).
   function automatic logic [4:0] ref_sel(input logic [1:0] sz, input logic [31:0] adr);
      int n;
      int a;
      if (sz == 2'd3) return 5'b0;
      n = 1 << sz;
      a = int'(adr % 32'd4);
      if ((a % n) != 0) return 5'b0;
      return {1'b1, 4'(((1 << n) - 1) << (4 - n - a))};
   endfunction

   // One transaction; entered and left on a negedge with the pipeline enabled.
   task automatic txn(input logic we, input logic [1:0] sz, input logic [31:0] adr,
                      input int waits, input logic [31:0] dat,
                      input logic [3:0] exp_sel, input logic exp_mis);
      int    bus_cyc;
      int    exp_stall;
      logic  to;
      to = !exp_mis && (waits >= TO);
      exp_stall = (waits + 1 < TO) ? waits + 1 : TO;
      req_i = 1'b1; we_i = we; size_i = sz; adr_i = adr;
      @(negedge gclk);
      req_i = 1'b0; adr_i = $urandom; size_i = 2'($urandom);
      if (exp_mis) begin
         chk("mis_cyc", 32'(dwb_cyc_o), 32'd0);
         chk("mis_err", 32'(err_o), 32'd1);
         chk("mis_gena", 32'(gena_o), 32'd1);
         @(negedge gclk);
         chk("mis_err_clr", 32'(err_o), 32'd0);
         chk("mis_ld_hold", ld_dat_o, model_ld);
         return;
      end
      chk("bus_adr", 32'(dwb_adr_o), 32'(adr >> 2));
      chk("bus_sel", 32'(dwb_sel_o), 32'(exp_sel));
      chk("bus_we", 32'(dwb_we_o), 32'(we));
      bus_cyc = 0;
      while (dwb_cyc_o && bus_cyc < 64) begin
         chk("bus_stb", 32'(dwb_stb_o), 32'd1);
         chk("bus_gena", 32'(gena_o), 32'd0);
         dwb_ack_i = (bus_cyc == waits);
         dwb_dat_i = dat;
         @(negedge gclk);
         bus_cyc++;
         dwb_ack_i = 1'b0;
         dwb_dat_i = $urandom;
      end
      chk("stall_len", 32'(bus_cyc), 32'(exp_stall));
      if (to) model_ld = 32'h0;
      else if (!we) model_ld = dat;
      chk("wb_err", 32'(err_o), 32'(to));
      chk("wb_ld", ld_dat_o, model_ld);
      chk("wb_sel", 32'(sel_o), 32'(exp_sel));
      chk("wb_gena", 32'(gena_o), 32'd1);
      chk("wb_stb", 32'(dwb_stb_o), 32'd0);
      @(negedge gclk);
      chk("idle_cyc", 32'(dwb_cyc_o), 32'd0);
      chk("idle_err", 32'(err_o), 32'd0);
      chk("idle_wsel_hold", 32'(dwb_sel_o), 32'(exp_sel));
   endtask

   initial begin
      logic [4:0] rs;
      n_chk = 0; n_fail = 0; model_ld = 32'h0;
      grst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'd0; adr_i = 32'h0;
      dwb_ack_i = 1'b0; dwb_dat_i = 32'h0;

      //                we    size   adr            waits dat            sel   mis
      vecs[0]  = '{1'b0, 2'd2, 32'h0000_1004, 0,  32'hDEAD_BEEF, 4'hF, 1'b0};
      vecs[1]  = '{1'b1, 2'd0, 32'h0000_0013, 3,  32'h1111_2222, 4'h1, 1'b0};
      vecs[2]  = '{1'b0, 2'd2, 32'h0000_0002, 0,  32'h0,         4'h0, 1'b1};
      vecs[3]  = '{1'b0, 2'd1, 32'h0000_0001, 0,  32'h0,         4'h0, 1'b1};
      vecs[4]  = '{1'b0, 2'd3, 32'h0000_0000, 0,  32'h0,         4'h0, 1'b1};
      vecs[5]  = '{1'b0, 2'd2, 32'h0000_0100, 10, 32'h5555_AAAA, 4'hF, 1'b0};
      vecs[6]  = '{1'b0, 2'd1, 32'h0000_0202, 3,  32'h1234_5678, 4'h3, 1'b0};
      vecs[7]  = '{1'b0, 2'd0, 32'h0000_0010, 1,  32'hCAFE_F00D, 4'h8, 1'b0};
      vecs[8]  = '{1'b0, 2'd0, 32'h0000_0011, 0,  32'h0BAD_CAFE, 4'h4, 1'b0};
      vecs[9]  = '{1'b1, 2'd0, 32'h0000_0012, 2,  32'h0,         4'h2, 1'b0};
      vecs[10] = '{1'b1, 2'd1, 32'h0000_0020, 0,  32'h0,         4'hC, 1'b0};
      vecs[11] = '{1'b1, 2'd2, 32'h0000_0040, 9,  32'h0,         4'hF, 1'b0};

      @(negedge gclk);
      @(negedge gclk);
      grst = 1'b0;
      chk("rst_gena", 32'(gena_o), 32'd1);
      chk("rst_err", 32'(err_o), 32'd0);
      chk("rst_cyc", 32'(dwb_cyc_o), 32'd0);
      chk("rst_stb", 32'(dwb_stb_o), 32'd0);
      chk("rst_we", 32'(dwb_we_o), 32'd0);
      chk("rst_adr", 32'(dwb_adr_o), 32'd0);
      chk("rst_wsel", 32'(dwb_sel_o), 32'd0);
      chk("rst_sel", 32'(sel_o), 32'd0);
      chk("rst_ld", ld_dat_o, 32'd0);

      // late ack outside BUS is ignored
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hFFFF_FFFF;
      @(negedge gclk);
      dwb_ack_i = 1'b0;
      chk("idle_ack_ld", ld_dat_o, 32'd0);
      chk("idle_ack_gena", 32'(gena_o), 32'd1);

      for (int i = 0; i < 12; i++) begin
         txn(vecs[i].we, vecs[i].size, vecs[i].adr, vecs[i].waits, vecs[i].dat,
             vecs[i].exp_sel, vecs[i].exp_mis);
      end

      // back-to-back: second request during WB; request during BUS ignored
      req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; adr_i = 32'h0000_0040;
      @(negedge gclk);
      req_i = 1'b0;
      chk("b2b_stb1", 32'(dwb_stb_o), 32'd1);
      chk("b2b_adr1", 32'(dwb_adr_o), 32'h10);
      dwb_ack_i = 1'b1; dwb_dat_i = 32'hA5A5_A5A5;
      @(negedge gclk);
      dwb_ack_i = 1'b0;
      chk("b2b_wb_stb", 32'(dwb_stb_o), 32'd0);
      chk("b2b_wb_gena", 32'(gena_o), 32'd1);
      chk("b2b_wb_ld", ld_dat_o, 32'hA5A5_A5A5);
      model_ld = 32'hA5A5_A5A5;
      req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; adr_i = 32'h0000_0080;
      @(negedge gclk);
      chk("b2b_stb2", 32'(dwb_stb_o), 32'd1);
      chk("b2b_adr2", 32'(dwb_adr_o), 32'h20);
      chk("b2b_we2", 32'(dwb_we_o), 32'd1);
      size_i = 2'd3; adr_i = 32'h0000_0001;
      @(negedge gclk);
      req_i = 1'b0;
      chk("b2b_ign_err", 32'(err_o), 32'd0);
      chk("b2b_ign_stb", 32'(dwb_stb_o), 32'd1);
      chk("b2b_ign_adr", 32'(dwb_adr_o), 32'h20);
      dwb_ack_i = 1'b1; dwb_dat_i = 32'h0F0F_0F0F;
      @(negedge gclk);
      dwb_ack_i = 1'b0;
      chk("b2b_wb2_err", 32'(err_o), 32'd0);
      chk("b2b_wb2_ld", ld_dat_o, model_ld);
      @(negedge gclk);
      chk("b2b_idle_cyc", 32'(dwb_cyc_o), 32'd0);
      chk("b2b_idle_err", 32'(err_o), 32'd0);

      // randomized transactions against the reference model
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  sz;
         logic [31:0] ad;
         sz = 2'($urandom_range(0, 3));
         ad = $urandom;
         rs = ref_sel(sz, ad);
         txn(1'($urandom), sz, ad, int'($urandom_range(0, 6)), $urandom, rs[3:0], ~rs[4]);
      end

      // reset in the middle of a bus cycle
      req_i = 1'b1; we_i = 1'b1; size_i = 2'd2; adr_i = 32'h0000_0300;
      @(negedge gclk);
      req_i = 1'b0;
      chk("mrst_stb_pre", 32'(dwb_stb_o), 32'd1);
      grst = 1'b1;
      @(negedge gclk);
      grst = 1'b0;
      chk("mrst_cyc", 32'(dwb_cyc_o), 32'd0);
      chk("mrst_stb", 32'(dwb_stb_o), 32'd0);
      chk("mrst_we", 32'(dwb_we_o), 32'd0);
      chk("mrst_gena", 32'(gena_o), 32'd1);
      chk("mrst_err", 32'(err_o), 32'd0);
      chk("mrst_adr", 32'(dwb_adr_o), 32'd0);
      chk("mrst_wsel", 32'(dwb_sel_o), 32'd0);
      chk("mrst_sel", 32'(sel_o), 32'd0);
      chk("mrst_ld", ld_dat_o, 32'd0);
      dwb_ack_i = 1'b1; dwb_dat_i = 32'h7777_7777;
      @(negedge gclk);
      dwb_ack_i = 1'b0;
      chk("late_ack_cyc", 32'(dwb_cyc_o), 32'd0);
      chk("late_ack_ld", ld_dat_o, 32'd0);
      chk("late_ack_err", 32'(err_o), 32'd0);
      chk("late_ack_gena", 32'(gena_o), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
